timer_sequencer: RTL

- CPU-side driver for the quarter-second hardware timer: the initiator end of its Start/FinishPulse handshake.
- The CPU writes an interval count over the memory-mapped register port.
- The block issues back-to-back Start pulses, counts FinishPulse returns, and raises done/IRQ after the last one.
- A watchdog flags a timer that never finishes, so game-loop pacing code (ball/paddle tick) cannot hang.

---
 rtl/timer_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/timer_sequencer.sv
// Initiator side of the quarter-second timer Start/FinishPulse handshake:
// issues a programmed number of back-to-back intervals under a watchdog.
module timer_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 32'd20000100,
  parameter int unsigned TO_W    = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [1:0]       Addr,
  input  logic             WE,
  input  logic [CNT_W-1:0] WriteData,
  output logic [CNT_W-1:0] ReadData,
  output logic             TimerStart,
  input  logic             TimerFinish,
  input  logic             TimerBusy,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic             IRQ
);

  localparam logic [1:0]      ADDR_COUNT  = 2'd0;
  localparam logic [1:0]      ADDR_STATUS = 2'd1;
  localparam logic [1:0]      ADDR_CTRL   = 2'd2;
  localparam logic [TO_W-1:0] TIMEOUT_C   = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic [TO_W-1:0]  wd_cnt, wd_next, wd_inc;
  logic             start_q, start_next;
  logic             done_q, done_next;
  logic             error_q, error_next;
  logic             irq_q, irq_next;
  logic             wr_count, wr_ctrl, abort, clear;

  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    state_next     = state;
    remaining_next = remaining;
    wd_next        = wd_cnt;
    start_next     = 1'b0;
    irq_next       = 1'b0;
    done_next      = done_q;
    error_next     = error_q;

    wr_count = WE && (Addr == ADDR_COUNT);
    wr_ctrl  = WE && (Addr == ADDR_CTRL);
    abort    = wr_ctrl && WriteData[0];
    clear    = wr_ctrl && WriteData[1];
    wd_inc   = (wd_cnt == TIMEOUT_C) ? wd_cnt : wd_cnt + 1'b1;

    // Clear is applied first so a flag set below in the same cycle wins.
    if (clear) begin
      done_next  = 1'b0;
      error_next = 1'b0;
    end

    unique case (state)
      S_IDLE: begin
        if (wr_count) begin
          if (WriteData != '0) begin
            remaining_next = WriteData;
            done_next      = 1'b0;
            error_next     = 1'b0;
            state_next     = S_ISSUE;
          end else begin
            done_next = 1'b1;
            irq_next  = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        if (abort) begin
          remaining_next = '0;
          state_next     = S_IDLE;
        end else if (!TimerBusy) begin
          start_next = 1'b1;
          wd_next    = '0;
          state_next = S_WAIT;
        end
      end

      // TimerBusy is not consulted here: only FinishPulse ends an interval.
      S_WAIT: begin
        if (abort) begin
          remaining_next = '0;
          state_next     = S_IDLE;
        end else begin
          wd_next = wd_inc;
          if (TimerFinish) begin
            if (remaining != '0) remaining_next = remaining - 1'b1;
            if (remaining <= CNT_W'(1)) begin
              done_next  = 1'b1;
              irq_next   = 1'b1;
              state_next = S_DONE;
            end else begin
              state_next = S_ISSUE;
            end
          end else if (wd_inc == TIMEOUT_C) begin
            error_next = 1'b1;
            irq_next   = 1'b1;
            state_next = S_DONE;
          end
        end
      end

      S_DONE: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register updates together at the edge.
    if (!RST_N) begin
      state     <= S_IDLE;
      remaining <= '0;
      wd_cnt    <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      wd_cnt    <= wd_next;
      start_q   <= start_next;
      done_q    <= done_next;
      error_q   <= error_next;
      irq_q     <= irq_next;
    end
  end

  assign TimerStart = start_q;
  assign Busy       = (state == S_ISSUE) || (state == S_WAIT);
  assign Done       = done_q;
  assign Error      = error_q;
  assign IRQ        = irq_q;

  always_comb begin
    unique case (Addr)
      ADDR_COUNT:  ReadData = remaining;
      ADDR_STATUS: ReadData = {{(CNT_W-3){1'b0}}, error_q, done_q, Busy};
      default:     ReadData = '0;
    endcase
  end

endmodule
